// File: rtl/encoder_4to2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : encoder_4to2_pipe
// Description : 4-to-2 priority encoder with a single-entry registered output
//               stage and valid/ready handshaking on both sides.
//               Multi-hot words resolve to the highest (HIGH_PRIO=1) or
//               lowest (HIGH_PRIO=0) set index and flag multi_err; an
//               all-zero word encodes to 00 and flags none_err. A saturating
//               counter tallies every captured word that raised a flag.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               en        - enable; gates acceptance of new words only
//               in_valid  - D holds a word to encode
//               D[3:0]    - one-hot input word (bit k <-> decoder output Yk)
//               in_ready  - block accepts D this cycle
//               out_ready - downstream accepts the output this cycle
//               out_valid - A, B, multi_err, none_err are valid
//               A, B      - encoded index, {A,B}, A is the MSB
//               multi_err - captured word had two or more bits set
//               none_err  - captured word was 0000
//               err_cnt   - saturating count of flagged captured words
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_4to2_pipe #(
    parameter int HIGH_PRIO = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [3:0]       D,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             A,
    output logic             B,
    output logic             multi_err,
    output logic             none_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_in_ready;
    logic             w_capture;
    logic [1:0]       w_idx;
    logic             w_multi;
    logic             w_none;
    logic [1:0]       r_idx;
    logic             r_multi;
    logic             r_none;
    logic [CNT_W-1:0] r_err_cnt;

    // A full register may still accept when the held word leaves this same
    // cycle, which gives back-to-back throughput without a bubble.
    assign w_in_ready = en & ((r_state == c_ST_EMPTY) | out_ready);
    assign w_capture  = in_valid & w_in_ready;

    // D & (D-1) clears the lowest set bit; anything left means 2+ bits set.
    assign w_multi = (D & (D - 4'd1)) != 4'd0;
    assign w_none  = (D == 4'd0);

    generate
        if (HIGH_PRIO != 0) begin : g_high_prio
            always_comb begin
                w_idx = 2'd0;
                if (D[3])      w_idx = 2'd3;
                else if (D[2]) w_idx = 2'd2;
                else if (D[1]) w_idx = 2'd1;
            end
        end else begin : g_low_prio
            always_comb begin
                w_idx = 2'd0;
                if (D[0])      w_idx = 2'd0;
                else if (D[1]) w_idx = 2'd1;
                else if (D[2]) w_idx = 2'd2;
                else if (D[3]) w_idx = 2'd3;
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_capture) w_state_nxt = c_ST_FULL;
            c_ST_FULL:  if (!w_capture && out_ready) w_state_nxt = c_ST_EMPTY;
            default:    w_state_nxt = c_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload only loads on capture, so D is never sampled outside a
    // handshake and the held word stays put under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= 2'd0;
            r_multi   <= 1'b0;
            r_none    <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_capture) begin
            r_idx   <= w_idx;
            r_multi <= w_multi;
            r_none  <= w_none;
            if ((w_multi || w_none) && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == c_ST_FULL);
    assign A         = r_idx[1];
    assign B         = r_idx[0];
    assign multi_err = r_multi;
    assign none_err  = r_none;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_encoder_4to2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_4to2_pipe
// Description : Self-checking bench for encoder_4to2_pipe. Three instances
//               share one stimulus stream: default parameters, low-priority
//               resolution, and a 2-bit error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_4to2_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [3:0] D;
    logic       out_ready;

    logic       h_rdy, h_v, h_a, h_b, h_m, h_n;
    logic [7:0] h_cnt;
    logic       l_rdy, l_v, l_a, l_b, l_m, l_n;
    logic [7:0] l_cnt;
    logic       s_rdy, s_v, s_a, s_b, s_m, s_n;
    logic [1:0] s_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit       m_full;
    bit [1:0] m_hidx, m_lidx;
    bit       m_multi, m_none;
    int       m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    encoder_4to2_pipe #(.HIGH_PRIO(1), .CNT_W(8)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .D(D),
        .in_ready(h_rdy), .out_ready(out_ready), .out_valid(h_v),
        .A(h_a), .B(h_b), .multi_err(h_m), .none_err(h_n), .err_cnt(h_cnt));

    encoder_4to2_pipe #(.HIGH_PRIO(0), .CNT_W(8)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .D(D),
        .in_ready(l_rdy), .out_ready(out_ready), .out_valid(l_v),
        .A(l_a), .B(l_b), .multi_err(l_m), .none_err(l_n), .err_cnt(l_cnt));

    encoder_4to2_pipe #(.HIGH_PRIO(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .D(D),
        .in_ready(s_rdy), .out_ready(out_ready), .out_valid(s_v),
        .A(s_a), .B(s_b), .multi_err(s_m), .none_err(s_n), .err_cnt(s_cnt));

    function automatic bit exp_ready();
        return en && (!m_full || out_ready);
    endfunction

    // Advance one clock edge and update the model from the rules:
    // accept when valid & ready, drain when out_ready without accept.
    task automatic step();
        bit acc;
        int ones;
        acc = rst_n && in_valid && exp_ready();
        @(posedge clk);
        if (!rst_n) begin
            m_full = 0; m_hidx = 0; m_lidx = 0; m_multi = 0; m_none = 0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (acc) begin
            m_full = 1;
            m_hidx = 0;
            for (int k = 0; k < 4; k++) if (D[k]) m_hidx = 2'(k);
            m_lidx = 0;
            for (int k = 3; k >= 0; k--) if (D[k]) m_lidx = 2'(k);
            ones = $countones(D);
            m_multi = ones > 1;
            m_none  = ones == 0;
            if (m_multi || m_none) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end else if (out_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        en = 0; in_valid = 0; out_ready = 0; D = 4'd0;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({h_v, h_a, h_b, h_m, h_n, h_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hi: got v=%b ab=%b%b m=%b n=%b cnt=%0d, want all 0",
                     h_v, h_a, h_b, h_m, h_n, h_cnt);
        end
        checks++;
        if ({l_v, l_a, l_b, l_m, l_n, l_cnt, s_v, s_cnt} !== 16'd0) begin
            errors++;
            $display("FAIL reset_lo_sat: got lv=%b lcnt=%0d sv=%b scnt=%0d, want 0",
                     l_v, l_cnt, s_v, s_cnt);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        en = 1; out_ready = 1; in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            D = 4'(1 << k);
            step();
            checks++;
            if (h_v !== 1'b1 || {h_a, h_b} !== 2'(k) || h_m !== 1'b0 ||
                h_n !== 1'b0 || h_cnt !== 8'd0) begin
                errors++;
                $display("FAIL sweep_%0d: got v=%b ab=%b%b m=%b n=%b cnt=%0d, want v=1 ab=%b m=0 n=0 cnt=0",
                         k, h_v, h_a, h_b, h_m, h_n, h_cnt, 2'(k));
            end
            checks++;
            if ({l_a, l_b} !== 2'(k)) begin
                errors++;
                $display("FAIL sweep_lo_%0d: got ab=%b%b, want %b", k, l_a, l_b, 2'(k));
            end
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_back_pressure();
        do_reset();
        en = 1; in_valid = 1; out_ready = 0; D = 4'b0100;
        step();
        D = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (h_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_%0d: got in_ready=%b, want 0", c, h_rdy);
            end
            step();
            checks++;
            if (h_v !== 1'b1 || {h_a, h_b} !== 2'b10) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b ab=%b%b, want v=1 ab=10", c, h_v, h_a, h_b);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (h_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got in_ready=%b, want 1", h_rdy);
        end
        step();
        in_valid = 0;
        checks++;
        if (h_v !== 1'b1 || {h_a, h_b} !== 2'b00) begin
            errors++;
            $display("FAIL bp_replace: got v=%b ab=%b%b, want v=1 ab=00", h_v, h_a, h_b);
        end
        step();
    endtask

    task automatic test_errors();
        do_reset();
        en = 1; in_valid = 1; out_ready = 1; D = 4'b1010;
        step();
        checks++;
        if ({h_a, h_b, h_m, h_n} !== 4'b1110 || {l_a, l_b, l_m, l_n} !== 4'b0110) begin
            errors++;
            $display("FAIL err_multi: got hi ab=%b%b m=%b n=%b lo ab=%b%b m=%b n=%b, want hi 11/1/0 lo 01/1/0",
                     h_a, h_b, h_m, h_n, l_a, l_b, l_m, l_n);
        end
        D = 4'b0000;
        step();
        checks++;
        if ({h_v, h_a, h_b, h_m, h_n} !== 5'b10001 || h_cnt !== 8'd2 || l_cnt !== 8'd2) begin
            errors++;
            $display("FAIL err_none: got v=%b ab=%b%b m=%b n=%b cnt=%0d/%0d, want 1 00 0 1 cnt=2",
                     h_v, h_a, h_b, h_m, h_n, h_cnt, l_cnt);
        end
        D = 4'b0010;
        step();
        in_valid = 0;
        checks++;
        if ({h_m, h_n} !== 2'b00 || h_cnt !== 8'd2) begin
            errors++;
            $display("FAIL err_not_sticky: got m=%b n=%b cnt=%0d, want 0 0 cnt=2", h_m, h_n, h_cnt);
        end
        step();
    endtask

    task automatic test_enable();
        do_reset();
        en = 1; in_valid = 1; out_ready = 0; D = 4'b1000;
        step();
        en = 0; D = 4'b0001;
        #1;
        checks++;
        if (h_rdy !== 1'b0) begin
            errors++;
            $display("FAIL en_ready: got in_ready=%b, want 0", h_rdy);
        end
        step();
        checks++;
        if (h_v !== 1'b1 || {h_a, h_b} !== 2'b11) begin
            errors++;
            $display("FAIL en_hold: got v=%b ab=%b%b, want v=1 ab=11", h_v, h_a, h_b);
        end
        out_ready = 1;
        #1;
        checks++;
        if (h_rdy !== 1'b0) begin
            errors++;
            $display("FAIL en_ready_drain: got in_ready=%b, want 0", h_rdy);
        end
        step();
        checks++;
        if (h_v !== 1'b0) begin
            errors++;
            $display("FAIL en_drain: got v=%b, want 0", h_v);
        end
        en = 1;
        step();
        in_valid = 0;
        checks++;
        if (h_v !== 1'b1 || {h_a, h_b} !== 2'b00) begin
            errors++;
            $display("FAIL en_resume: got v=%b ab=%b%b, want v=1 ab=00", h_v, h_a, h_b);
        end
        step();
    endtask

    task automatic test_saturation();
        logic [1:0] want [5];
        want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        en = 1; in_valid = 1; out_ready = 1; D = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (s_cnt !== want[i] || s_m !== 1'b1) begin
                errors++;
                $display("FAIL sat_%0d: got cnt=%0d m=%b, want cnt=%0d m=1", i, s_cnt, s_m, want[i]);
            end
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1; in_valid = 1; out_ready = 0; D = 4'b0110;
        step();
        #3 rst_n = 0;
        #1;
        checks++;
        if ({h_v, h_a, h_b, h_m, h_n, h_cnt} !== 13'd0 || s_cnt !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b ab=%b%b m=%b n=%b cnt=%0d, want all 0 before edge",
                     h_v, h_a, h_b, h_m, h_n, h_cnt);
        end
        step();
        checks++;
        if (h_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture: got v=%b, want 0", h_v);
        end
        #2 rst_n = 1;
        D = 4'b0100;
        step();
        in_valid = 0;
        checks++;
        if (h_v !== 1'b1 || {h_a, h_b} !== 2'b10) begin
            errors++;
            $display("FAIL reset_resume: got v=%b ab=%b%b, want v=1 ab=10", h_v, h_a, h_b);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            D         = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (h_rdy !== exp_ready() || l_rdy !== exp_ready() || s_rdy !== exp_ready()) begin
                errors++;
                $display("FAIL rnd_ready_%0d: got %b/%b/%b, want %b", i, h_rdy, l_rdy, s_rdy, exp_ready());
            end
            step();
            checks++;
            if (h_v !== m_full || l_v !== m_full || s_v !== m_full ||
                (m_full && ({h_a, h_b, h_m, h_n} !== {m_hidx, m_multi, m_none} ||
                            {l_a, l_b, l_m, l_n} !== {m_lidx, m_multi, m_none} ||
                            {s_a, s_b, s_m, s_n} !== {m_hidx, m_multi, m_none}))) begin
                errors++;
                $display("FAIL rnd_out_%0d: got hi v=%b %b%b%b%b lo v=%b %b%b%b%b, want v=%b hi %b lo %b m=%b n=%b",
                         i, h_v, h_a, h_b, h_m, h_n, l_v, l_a, l_b, l_m, l_n,
                         m_full, m_hidx, m_lidx, m_multi, m_none);
            end
            checks++;
            if (h_cnt !== 8'(m_cnt8) || l_cnt !== 8'(m_cnt8) || s_cnt !== 2'(m_cnt2)) begin
                errors++;
                $display("FAIL rnd_cnt_%0d: got %0d/%0d/%0d, want %0d/%0d",
                         i, h_cnt, l_cnt, s_cnt, m_cnt8, m_cnt2);
            end
        end
    endtask

    initial begin
        rst_n = 0; en = 0; in_valid = 0; out_ready = 0; D = 4'd0;
        test_reset();
        test_sweep();
        test_back_pressure();
        test_errors();
        test_enable();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encoder_4to2_pipe.md
ENCODER_4TO2_PIPE -- requirements
Module: encoder_4to2_pipe

Interface
REQ-001 SHALL have parameter HIGH_PRIO, default 1, meaning multi-hot inputs resolve to highest set index (1) or lowest set index (0).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the error counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  block enable; gates acceptance of new words only.
REQ-007 SHALL have port in_valid  input  1  D holds a word to encode.
REQ-008 SHALL have port D  input  4  one-hot word; bit k corresponds to decoder output Yk.
REQ-009 SHALL have port in_ready  output  1  block accepts D this cycle.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output this cycle.
REQ-011 SHALL have port out_valid  output  1  A, B, multi_err and none_err are valid.
REQ-012 SHALL have ports A and B, each  output  1  encoded index, A = MSB, so index = {A,B}.
REQ-013 SHALL have port multi_err  output  1  captured word had two or more bits set.
REQ-014 SHALL have port none_err  output  1  captured word was 0000.
REQ-015 SHALL have port err_cnt  output  CNT_W  count of captured words with multi_err or none_err.

Function
REQ-016 SHALL implement a single-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 SHALL drive in_ready = en AND (state==EMPTY OR out_ready), combinationally.
REQ-018 SHALL capture D on a rising edge where in_valid AND in_ready; out_valid rises on that edge (latency 1 cycle).
REQ-019 SHALL transition EMPTY->FULL on capture; FULL->EMPTY on out_ready without capture; FULL->FULL on simultaneous out_ready and capture (new word replaces old, no bubble, full throughput).
REQ-020 SHALL hold A, B, multi_err and none_err stable while out_valid=1 and out_ready=0.
REQ-021 SHALL encode one-hot D as: 0001->00, 0010->01, 0100->10, 1000->11.
REQ-022 SHALL, for multi-hot D, output the highest set index when HIGH_PRIO=1 or the lowest when HIGH_PRIO=0, and set multi_err=1 for that word.
REQ-023 SHALL, for D=0000, output {A,B}=00 with none_err=1 and multi_err=0.
REQ-024 SHALL have multi_err and none_err mutually exclusive and per-word (not sticky).
REQ-025 SHALL increment err_cnt by 1 on each capture whose word sets multi_err or none_err, saturating at all-ones.
REQ-026 SHALL, when en=0, refuse new words (in_ready=0) while still presenting and draining an already-held word via out_ready.
REQ-027 SHALL ignore D while in_valid=0 or in_ready=0; X on D in those cycles SHALL not propagate.

Reset
REQ-028 SHALL, on rst_n low, immediately force state=EMPTY, out_valid=0, A=0, B=0, multi_err=0, none_err=0, err_cnt=0, independent of clk.
REQ-029 SHALL discard any held word on reset mid-operation; no capture occurs on the edge where rst_n is low.
REQ-030 SHALL resume normal capture on the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset: assert rst_n=0 mid-cycle with FULL state -> out_valid, A, B, errors, err_cnt all 0 before next edge.
REQ-032 Sweep: en=1, out_ready=1, D=0001,0010,0100,1000 on consecutive cycles -> {A,B}=00,01,10,11 one cycle later each, out_valid held 1, no errors, err_cnt=0.
REQ-033 Back-pressure: capture D=0100, out_ready=0 for 3 cycles with in_valid=1, D=0001 -> in_ready=0, {A,B}=10 held; out_ready=1 -> 0001 captured same edge, next {A,B}=00.
REQ-034 Errors: HIGH_PRIO=1, D=1010 -> {A,B}=11, multi_err=1; D=0000 -> {A,B}=00, none_err=1; err_cnt=2; repeat with HIGH_PRIO=0, D=1010 -> {A,B}=01.
REQ-035 Enable: FULL with en=0, in_valid=1 -> in_ready=0, no capture; out_ready=1 drains to EMPTY; en=1 resumes capture.
REQ-036 Saturation: CNT_W=2, capture 5 words of D=0011 -> err_cnt sequence 1,2,3,3,3.
